// File: rtl/tsall_pkg.sv
// tsall_pkg: shared types and constants for the tristate-all sequencer.
//   - tsall_state_e : sequencer state encoding
//   - TSALL_CNT_W_DEF / cnt_fits() : phase-counter width default and range helper
//   - *_RST : values the registered outputs take while RST is high
package tsall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREWARN = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_GUARD   = 2'd3
    } tsall_state_e;

    localparam int TSALL_CNT_W_DEF = 16;

    // True when a cycle count can be loaded into a counter of the given width.
    function automatic bit cnt_fits(input int value, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return (value < (1 << width));
    endfunction

    localparam logic TSALLN_RST = 1'b1;
    localparam logic WARN_RST   = 1'b0;
    localparam logic BUSY_RST   = 1'b0;
    localparam logic DONE_RST   = 1'b0;

endpackage

// File: rtl/tsall_debounce.sv
// tsall_debounce: synchroniser plus stability filter for the board request.
//   CLK     : clock
//   RST     : synchronous active-high reset, clears synchroniser and filter
//   D_ASYNC : asynchronous input level
//   Q       : filtered level; changes only after the synchronised input has
//             disagreed with it for DEBOUNCE_CYC consecutive cycles
module tsall_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic D_ASYNC,
    output logic Q
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_out;
    logic                   q_p1;
    logic [DB_W-1:0]        cnt_p1;

    // Stage 0: synchroniser chain, oldest sample in the MSB.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], D_ASYNC};
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];

    // Stage 1: stability filter. The count tracks how many consecutive cycles
    // the synchronised level has disagreed with Q; the disagreeing cycle that
    // would make it DEBOUNCE_CYC flips Q instead.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_p1   <= 1'b0;
            cnt_p1 <= '0;
        end else if (sync_out != q_p1) begin
            if (cnt_p1 == DB_W'(DEBOUNCE_CYC - 1)) begin
                q_p1   <= sync_out;
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= cnt_p1 + DB_W'(1);
            end
        end else begin
            cnt_p1 <= '0;
        end
    end

    assign Q = q_p1;

endmodule

// File: rtl/tsall_ctrl.sv
// tsall_ctrl: sequencer in front of the global tristate-all primitive.
//   CLK       : clock, rising edge
//   RST       : synchronous active-high reset
//   REQ_ASYNC : asynchronous board request (synchronised + debounced here)
//   SW_REQ    : synchronous software request level
//   FORCE     : synchronous emergency request, bypasses the pre-warning
//   TSALLN    : registered active-low tristate-all drive
//   WARN      : registered, high while pre-warning I/O owners
//   BUSY      : registered, high whenever the sequencer is not idle
//   DONE      : registered one-cycle pulse on the last guard cycle
module tsall_ctrl
    import tsall_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int PREWARN_CYC  = 4,
    parameter int MIN_HOLD_CYC = 256,
    parameter int GUARD_CYC    = 8,
    parameter int CNT_W        = TSALL_CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_ASYNC,
    input  logic SW_REQ,
    input  logic FORCE,
    output logic TSALLN,
    output logic WARN,
    output logic BUSY,
    output logic DONE
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("tsall_ctrl: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYC < 1 || PREWARN_CYC < 1 || MIN_HOLD_CYC < 1 || GUARD_CYC < 1) begin : g_chk_min
        $error("tsall_ctrl: cycle parameters must be at least 1");
    end
    if (!cnt_fits(DEBOUNCE_CYC, CNT_W) || !cnt_fits(PREWARN_CYC, CNT_W) ||
        !cnt_fits(MIN_HOLD_CYC, CNT_W) || !cnt_fits(GUARD_CYC, CNT_W)) begin : g_chk_w
        $error("tsall_ctrl: a cycle parameter does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LD_PREWARN = CNT_W'(PREWARN_CYC);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(MIN_HOLD_CYC);
    localparam logic [CNT_W-1:0] LD_GUARD   = CNT_W'(GUARD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             req_db;
    logic             req;
    tsall_state_e     state_p0;
    tsall_state_e     state_nxt;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_dec;
    logic             expired;
    logic             tsalln_d;
    logic             warn_d;
    logic             busy_d;
    logic             done_d;
    logic             tsalln_p0;
    logic             warn_p0;
    logic             busy_p0;
    logic             done_p0;

    tsall_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .CLK     (CLK),
        .RST     (RST),
        .D_ASYNC (REQ_ASYNC),
        .Q       (req_db)
    );

    assign req     = req_db | SW_REQ;
    assign expired = (cnt_p0 == CNT_ONE);
    // The counter parks at 1 so ASSERT can wait for the request to drop
    // after the hold time without the count wrapping.
    assign cnt_dec = (cnt_p0 > CNT_ONE) ? (cnt_p0 - CNT_ONE) : cnt_p0;

    // Stage 0: state, counter and registered outputs. Outputs are decoded
    // from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p0  <= ST_IDLE;
            cnt_p0    <= '0;
            tsalln_p0 <= TSALLN_RST;
            warn_p0   <= WARN_RST;
            busy_p0   <= BUSY_RST;
            done_p0   <= DONE_RST;
        end else begin
            state_p0  <= state_nxt;
            cnt_p0    <= cnt_nxt;
            tsalln_p0 <= tsalln_d;
            warn_p0   <= warn_d;
            busy_p0   <= busy_d;
            done_p0   <= done_d;
        end
    end

    // Next state and counter; FORCE wins over req at every decision.
    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_dec;
        case (state_p0)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (FORCE) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = LD_HOLD;
                end else if (req) begin
                    state_nxt = ST_PREWARN;
                    cnt_nxt   = LD_PREWARN;
                end
            end
            ST_PREWARN: begin
                if (FORCE || (req && expired)) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = LD_HOLD;
                end else if (!req) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_ASSERT: begin
                if (expired && !req && !FORCE) begin
                    state_nxt = ST_GUARD;
                    cnt_nxt   = LD_GUARD;
                end
            end
            ST_GUARD: begin
                if (FORCE) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = LD_HOLD;
                end else if (expired) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the next state. DONE marks the final guard cycle,
    // i.e. the cycle whose counter value will expire on the following edge.
    always_comb begin
        tsalln_d = (state_nxt != ST_ASSERT);
        warn_d   = (state_nxt == ST_PREWARN);
        busy_d   = (state_nxt != ST_IDLE);
        done_d   = (state_nxt == ST_GUARD) && (cnt_nxt == CNT_ONE);
    end

    assign TSALLN = tsalln_p0;
    assign WARN   = warn_p0;
    assign BUSY   = busy_p0;
    assign DONE   = done_p0;

endmodule

// File: tb/tb_tsall_ctrl.sv
// tb_tsall_ctrl: directed-vector bench for tsall_ctrl with short cycle
// parameters. Inputs change 1 ns after a rising edge; outputs are checked
// at the same point, so the value seen after "edge k" is the one the
// design registered on the edge that sampled the inputs set before it.
module tb_tsall_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic REQ_ASYNC;
    logic SW_REQ;
    logic FORCE;
    logic TSALLN;
    logic WARN;
    logic BUSY;
    logic DONE;

    int vectors     = 0;
    int miscompares = 0;
    bit inv_en      = 1'b0;

    tsall_ctrl #(
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (5),
        .PREWARN_CYC  (4),
        .MIN_HOLD_CYC (10),
        .GUARD_CYC    (3),
        .CNT_W        (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_ASYNC (REQ_ASYNC),
        .SW_REQ    (SW_REQ),
        .FORCE     (FORCE),
        .TSALLN    (TSALLN),
        .WARN      (WARN),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int k, input logic tsalln_e,
                              input logic warn_e, input logic busy_e, input logic done_e);
        expect_eq($sformatf("%s_tsalln@%0d", tag, k), {31'd0, TSALLN}, {31'd0, tsalln_e});
        expect_eq($sformatf("%s_warn@%0d", tag, k),   {31'd0, WARN},   {31'd0, warn_e});
        expect_eq($sformatf("%s_busy@%0d", tag, k),   {31'd0, BUSY},   {31'd0, busy_e});
        expect_eq($sformatf("%s_done@%0d", tag, k),   {31'd0, DONE},   {31'd0, done_e});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
    endtask

    // Invariants, every cycle once the design has been reset.
    always @(negedge CLK) begin
        if (inv_en) begin
            expect_eq("inv_warn_and_tsalln_low", {31'd0, WARN & ~TSALLN}, 32'd0);
            expect_eq("inv_tsalln_low_not_busy", {31'd0, ~TSALLN & ~BUSY}, 32'd0);
        end
    end

    initial begin
        RST       = 1'b1;
        REQ_ASYNC = 1'b0;
        SW_REQ    = 1'b0;
        FORCE     = 1'b0;
        tick();
        tick();
        expect_out("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
        RST    = 1'b0;
        inv_en = 1'b1;
        tick();
        expect_out("idle", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Software request, dropped so that edge 21 samples it low.
        SW_REQ = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            tick();
            expect_out("sw", k, !(k >= 4 && k <= 20), k <= 3, k <= 23, k == 23);
            if (k == 20) SW_REQ = 1'b0;
        end

        // Board request glitches shorter than the debounce window.
        do_reset();
        for (int len = 1; len <= 4; len++) begin
            REQ_ASYNC = 1'b1;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (k + 1 >= len) REQ_ASYNC = 1'b0;
            end
            expect_out($sformatf("glitch%0d", len), 12, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Six-cycle stable board pulse: 2 sync + 5 debounce cycles to WARN.
        REQ_ASYNC = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            expect_out("board", k, 1'b1, k >= 7, k >= 7, 1'b0);
            REQ_ASYNC = (k + 1 < 6);
        end

        // Short software request aborts PREWARN.
        do_reset();
        SW_REQ = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            tick();
            expect_out("abort", k, 1'b1, k <= 1, k <= 1, 1'b0);
            if (k == 1) SW_REQ = 1'b0;
        end

        // FORCE from IDLE, then FORCE again during GUARD at edge 11.
        do_reset();
        FORCE = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            tick();
            expect_out("force", k, !(k <= 9 || (k >= 11 && k <= 20)), 1'b0, k <= 23, k == 23);
            FORCE = (k + 1 == 11);
        end

        // Reset in ASSERT at edge 7 with SW_REQ held; PREWARN restarts at 8.
        do_reset();
        SW_REQ = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k < 7)
                expect_out("rstmid", k, k < 4, k <= 3, 1'b1, 1'b0);
            else if (k == 7)
                expect_out("rstmid", k, 1'b1, 1'b0, 1'b0, 1'b0);
            else
                expect_out("rstmid", k, k < 12, k <= 11, 1'b1, 1'b0);
            RST = (k + 1 == 7);
        end
        SW_REQ = 1'b0;

        // Request re-raised during GUARD: GUARD completes, one IDLE cycle,
        // then PREWARN again.
        do_reset();
        SW_REQ = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            tick();
            expect_out("reguard", k, !(k >= 4 && k <= 20), (k <= 3) || (k >= 25),
                       (k <= 23) || (k >= 25), k == 23);
            if (k == 20) SW_REQ = 1'b0;
            if (k == 21) SW_REQ = 1'b1;
        end
        SW_REQ = 1'b0;
        do_reset();
        expect_out("final", 0, 1'b1, 1'b0, 1'b0, 1'b0);

        inv_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tsall_ctrl.md
Name: tsall_ctrl

Overview:
- Sequencer directly upstream of the global tristate-all primitive. It generates the registered, active-low TSALLN that drives the primitive's TSALLN input.
- It merges an asynchronous board-level request with a synchronous software request. The board request is synchronised and debounced.
- Before tristating, it gives I/O owners a pre-warning. It enforces a minimum tristate hold time and a post-release guard period.
- A FORCE input bypasses the warning for emergency isolation.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on REQ_ASYNC; minimum 2.
- DEBOUNCE_CYC, 16: consecutive stable cycles before the filtered request changes; minimum 1.
- PREWARN_CYC, 4: cycles WARN is high before TSALLN falls; minimum 1.
- MIN_HOLD_CYC, 256: minimum cycles TSALLN stays low; minimum 1.
- GUARD_CYC, 8: cycles BUSY stays high after TSALLN rises; minimum 1.
- CNT_W, 16: width of the shared phase counter. Every *_CYC parameter must be below 2**CNT_W; elaboration-time check.

Ports:
- CLK, in, 1: sole clock; all logic is on the rising edge.
- RST, in, 1: synchronous, active-high reset.
- REQ_ASYNC, in, 1: board tristate request, asynchronous, active-high.
- SW_REQ, in, 1: synchronous software request level, active-high.
- FORCE, in, 1: synchronous emergency request; skips PREWARN.
- TSALLN, out, 1: registered, active-low; feeds the tristate-all primitive.
- WARN, out, 1: registered; high during PREWARN.
- BUSY, out, 1: registered; high in every state except IDLE.
- DONE, out, 1: registered one-cycle pulse when GUARD completes.

Behaviour:
- Reset:
  - Takes effect on any edge where RST=1, including mid-sequence.
  - Next state IDLE; TSALLN=1, WARN=0, BUSY=0, DONE=0; counter=0.
  - Synchroniser flops and debounce filter cleared to 0.
  - Reset in ASSERT releases the pins on that edge.
- Request path:
  - REQ_ASYNC passes through SYNC_STAGES flops, then the debounce filter.
  - The filtered level flips only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles; any mismatch-free cycle restarts the count.
  - req = filtered REQ_ASYNC OR SW_REQ.
  - FORCE is not filtered.
- Counter: a single down-counter, loaded on state entry, decrements each cycle in PREWARN, ASSERT and GUARD; "expired" means it reads 1.
- FSM (states IDLE, PREWARN, ASSERT, GUARD; FORCE takes priority over req at every decision point):
  - IDLE: FORCE -> ASSERT. Else req -> PREWARN (counter loaded with PREWARN_CYC).
  - PREWARN, WARN=1:
    - FORCE -> ASSERT immediately.
    - req=0 -> IDLE (abort; TSALLN never falls; no DONE).
    - Counter expired -> ASSERT.
  - ASSERT, TSALLN=0 (counter loaded with MIN_HOLD_CYC):
    - Stays until the counter has expired AND req=0 AND FORCE=0, then -> GUARD.
    - Request removal before the hold ends is ignored until the hold completes.
  - GUARD, TSALLN=1, BUSY=1 (counter loaded with GUARD_CYC):
    - FORCE -> ASSERT, with the counter reloaded.
    - Counter expired -> IDLE with DONE=1 for that one cycle.
    - req reasserted during GUARD does not abort GUARD; being a level, it is served from IDLE afterwards via PREWARN.
- Latency (outputs registered; "edge k" is the edge that samples the input):
  - SW_REQ high at edge k: WARN=1 from k; TSALLN=0 from k+PREWARN_CYC.
  - FORCE high at edge k, in IDLE, PREWARN or GUARD: TSALLN=0 from k.
  - REQ_ASYNC adds SYNC_STAGES+DEBOUNCE_CYC cycles, ±1 for async sampling.
- Invariants:
  - WARN and TSALLN=0 are never true together.
  - TSALLN=0 always implies BUSY=1.
  - TSALLN never glitches: it is driven from a flop only.

Decomposition:
- Package tsall_pkg:
  - State enum (IDLE, PREWARN, ASSERT, GUARD).
  - Counter-width localparam helper.
  - Reset-value constants for the outputs.
- Sub-module tsall_debounce:
  - SYNC_STAGES synchroniser plus DEBOUNCE_CYC stability filter.
  - Ports CLK, RST, D_ASYNC, Q.
- Top: FSM and shared counter only.

Test Plan (bench parameters PREWARN_CYC=4, MIN_HOLD_CYC=10, GUARD_CYC=3, DEBOUNCE_CYC=5, SYNC_STAGES=2):
1. SW_REQ 1 at edge 0, dropped at edge 20 -> WARN high edges 0-3. TSALLN low edges 4-20. TSALLN high with BUSY from edge 21. DONE pulse at edge 23. IDLE at edge 24.
2. REQ_ASYNC glitches of 1-4 cycles -> TSALLN and WARN stay idle. A 6-cycle-stable pulse -> WARN rises 7±1 cycles after the pulse starts.
3. SW_REQ 1 for 2 cycles only -> PREWARN aborts to IDLE. TSALLN never 0; DONE never pulses.
4. FORCE pulse in IDLE at edge 0 -> TSALLN 0 at edge 0 with WARN=0. Release no earlier than edge 10 (MIN_HOLD); FORCE in GUARD -> back to ASSERT the next edge.
5. RST asserted in ASSERT at edge 7 -> TSALLN=1, BUSY=0, WARN=0 at edge 7. A held SW_REQ after RST falls restarts PREWARN.
6. Request held through GUARD -> DONE pulses, IDLE for one cycle, then PREWARN re-entered. Invariants checked every cycle by assertions.
